// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - plays a table of pulse durations from RAM as a gapped pulse train
module pulse_sequencer #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_pulses,
    input  logic [CNT_W-1:0]  gap,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CNT_W-1:0]  rd_data,
    output logic              pulse_out,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pulse_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_HIGH,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};

    state_t              state;
    logic                start_q;
    logic [ADDR_W:0]     n_lat;
    logic [CNT_W-1:0]    g_lat;
    logic [ADDR_W-1:0]   idx;
    logic [CNT_W-1:0]    cnt;

    logic                start_rise;
    logic                last;
    logic [ADDR_W-1:0]   idx_nxt;

    assign start_rise = start & ~start_q;
    assign last       = ({1'b0, idx} == (n_lat - (ADDR_W+1)'(1)));
    assign idx_nxt    = idx + ADDR_W'(1);

    // cnt holds remaining cycles minus one, so a count of D never needs D+1 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            n_lat     <= '0;
            g_lat     <= '0;
            idx       <= '0;
            cnt       <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_idx <= '0;
        end else begin
            start_q <= start;
            rd_en   <= 1'b0;
            done    <= 1'b0;
            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                pulse_out <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_rise) begin
                            n_lat <= (num_pulses > MAX_N) ? MAX_N : num_pulses;
                            g_lat <= gap;
                            idx   <= '0;
                            busy  <= 1'b1;
                            if (num_pulses == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= S_FETCH;
                                rd_en     <= 1'b1;
                                rd_addr   <= '0;
                                pulse_idx <= '0;
                            end
                        end
                    end
                    S_FETCH: state <= S_LOAD;
                    S_LOAD: begin
                        if (rd_data == '0) begin
                            if (last) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= S_FETCH;
                                idx       <= idx_nxt;
                                rd_en     <= 1'b1;
                                rd_addr   <= idx_nxt;
                                pulse_idx <= idx_nxt;
                            end
                        end else begin
                            cnt       <= rd_data - CNT_W'(1);
                            pulse_out <= 1'b1;
                            state     <= S_HIGH;
                        end
                    end
                    S_HIGH: begin
                        if (cnt == '0) begin
                            pulse_out <= 1'b0;
                            if (last) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else if (g_lat == '0) begin
                                state     <= S_FETCH;
                                idx       <= idx_nxt;
                                rd_en     <= 1'b1;
                                rd_addr   <= idx_nxt;
                                pulse_idx <= idx_nxt;
                            end else begin
                                cnt   <= g_lat - CNT_W'(1);
                                state <= S_GAP;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (cnt == '0) begin
                            state     <= S_FETCH;
                            idx       <= idx_nxt;
                            rd_en     <= 1'b1;
                            rd_addr   <= idx_nxt;
                            pulse_idx <= idx_nxt;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - directed bench for pulse_sequencer with a registered-read RAM model
module tb_pulse_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  num_pulses;
    logic [31:0] gap;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic [2:0]  pulse_idx;

    logic [31:0] ram [0:7];

    int n_checks = 0;
    int n_fail   = 0;

    logic mon_clr = 1'b0;
    int   rd_cnt, done_cnt, cur_hi, cur_lo;
    bit   seen_pulse, prev_p;
    int   addr_log[$];
    int   hi_len[$];
    int   lo_len[$];
    int   idx_log[$];

    pulse_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_pulses (num_pulses),
        .gap        (gap),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .done       (done),
        .pulse_idx  (pulse_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            rd_cnt = 0; done_cnt = 0; cur_hi = 0; cur_lo = 0;
            seen_pulse = 0; prev_p = 0;
            addr_log.delete(); hi_len.delete(); lo_len.delete(); idx_log.delete();
        end else begin
            if (rd_en) begin
                rd_cnt++;
                addr_log.push_back(int'(rd_addr));
            end
            if (done) done_cnt++;
            if (pulse_out) begin
                if (!prev_p) begin
                    if (seen_pulse) lo_len.push_back(cur_lo);
                    idx_log.push_back(int'(pulse_idx));
                    cur_hi = 1;
                end else cur_hi++;
            end else begin
                if (prev_p) begin
                    hi_len.push_back(cur_hi);
                    seen_pulse = 1;
                    cur_lo = 1;
                end else cur_lo++;
            end
            prev_p = pulse_out;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    // leaves the bench sampling cycle T+1, T being the edge that sees start high
    task automatic fire(input int n, input int g);
        num_pulses = 4'(n);
        gap        = 32'(g);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int i = 0;
        while (busy && i < budget) begin
            tick();
            i++;
        end
        chk(tag, busy, 0);
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_pulses = '0; gap = '0;
        for (int i = 0; i < 8; i++) ram[i] = 32'd0;
        tick();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_pulse", pulse_out, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        tick();

        // single 5-cycle pulse, cycle-exact
        ram[0] = 32'd5;
        clear_mon();
        fire(1, 0);
        chk("t1_busy_T1", busy, 1);
        chk("t1_rd_en_T1", rd_en, 1);
        chk("t1_rd_addr_T1", rd_addr, 0);
        tick();
        chk("t1_pulse_T2", pulse_out, 0);
        chk("t1_rd_en_T2", rd_en, 0);
        for (int c = 3; c <= 7; c++) begin
            tick();
            chk($sformatf("t1_pulse_T%0d", c), pulse_out, 1);
        end
        tick();
        chk("t1_pulse_T8", pulse_out, 0);
        chk("t1_done_T8", done, 1);
        chk("t1_busy_T8", busy, 1);
        tick();
        chk("t1_done_T9", done, 0);
        chk("t1_busy_T9", busy, 0);
        tick();
        chk("t1_rd_cnt", rd_cnt, 1);
        chk("t1_hi_len", hi_len[0], 5);
        chk("t1_done_cnt", done_cnt, 1);

        // three pulses with G = 10
        ram[0] = 32'd3; ram[1] = 32'd4; ram[2] = 32'd2;
        clear_mon();
        fire(3, 10);
        wait_idle(300, "t2_timeout");
        chk("t2_npulse", hi_len.size(), 3);
        chk("t2_hi0", hi_len[0], 3);
        chk("t2_hi1", hi_len[1], 4);
        chk("t2_hi2", hi_len[2], 2);
        chk("t2_lo0", lo_len[0], 12);
        chk("t2_lo1", lo_len[1], 12);
        chk("t2_addr0", addr_log[0], 0);
        chk("t2_addr1", addr_log[1], 1);
        chk("t2_addr2", addr_log[2], 2);
        chk("t2_rd_cnt", rd_cnt, 3);
        chk("t2_done_cnt", done_cnt, 1);

        // zero entry skipped
        ram[0] = 32'd4; ram[1] = 32'd0; ram[2] = 32'd6;
        clear_mon();
        fire(3, 1);
        wait_idle(300, "t3_timeout");
        chk("t3_npulse", hi_len.size(), 2);
        chk("t3_hi0", hi_len[0], 4);
        chk("t3_hi1", hi_len[1], 6);
        chk("t3_lo0", lo_len[0], 5);
        chk("t3_idx1", idx_log[1], 2);
        chk("t3_rd_cnt", rd_cnt, 3);
        chk("t3_done_cnt", done_cnt, 1);

        // N = 0
        clear_mon();
        fire(0, 5);
        chk("t4a_done_T1", done, 1);
        chk("t4a_busy_T1", busy, 1);
        tick();
        chk("t4a_done_T2", done, 0);
        chk("t4a_busy_T2", busy, 0);
        tick();
        chk("t4a_rd_cnt", rd_cnt, 0);
        chk("t4a_npulse", hi_len.size(), 0);

        // N = 15 clamps to 8
        for (int i = 0; i < 8; i++) ram[i] = 32'd1;
        clear_mon();
        fire(15, 0);
        wait_idle(300, "t4b_timeout");
        chk("t4b_rd_cnt", rd_cnt, 8);
        chk("t4b_addr7", addr_log[7], 7);
        chk("t4b_npulse", hi_len.size(), 8);
        chk("t4b_done_cnt", done_cnt, 1);

        // abort during second pulse of four
        ram[0] = 32'd2; ram[1] = 32'd3; ram[2] = 32'd2; ram[3] = 32'd2;
        clear_mon();
        fire(4, 2);
        for (int c = 2; c <= 9; c++) tick();
        chk("t5_pulse_T9", pulse_out, 1);
        chk("t5_idx_T9", pulse_idx, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_pulse_abort", pulse_out, 0);
        chk("t5_busy_abort", busy, 0);
        chk("t5_rd_en_abort", rd_en, 0);
        for (int c = 0; c < 10; c++) tick();
        chk("t5_no_done", done_cnt, 0);
        chk("t5_still_idle", busy, 0);
        clear_mon();
        fire(4, 2);
        chk("t5r_rd_en", rd_en, 1);
        chk("t5r_rd_addr", rd_addr, 0);
        wait_idle(300, "t5r_timeout");
        chk("t5r_rd_cnt", rd_cnt, 4);
        chk("t5r_done_cnt", done_cnt, 1);

        // start held high, plus a second edge while busy
        ram[0] = 32'd3; ram[1] = 32'd4; ram[2] = 32'd2;
        clear_mon();
        num_pulses = 4'd2;
        gap        = 32'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        wait_idle(300, "t6_timeout");
        for (int c = 0; c < 6; c++) tick();
        chk("t6_busy", busy, 0);
        chk("t6_rd_cnt", rd_cnt, 2);
        chk("t6_done_cnt", done_cnt, 1);
        start = 1'b0;
        tick();

        // async reset mid-GAP
        clear_mon();
        fire(3, 10);
        for (int c = 2; c <= 8; c++) tick();
        chk("t7_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_busy_async", busy, 0);
        chk("t7_pulse_async", pulse_out, 0);
        chk("t7_rd_en_async", rd_en, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        chk("t7_busy_post", busy, 0);
        chk("t7_pulse_post", pulse_out, 0);
        clear_mon();
        fire(1, 0);
        wait_idle(100, "t7r_timeout");
        chk("t7r_hi0", hi_len[0], 3);
        chk("t7r_done_cnt", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
